// File: rtl/operand_stack_if.sv
// Command/data bundle between a stack user and operand_stack.
// The master drives the four command strobes and the write data; the
// slave (the stack) returns its registered view of the top two entries,
// the occupancy and the illegal-command flag.
interface operand_stack_if;
  logic        push;
  logic        pop;
  logic        swap;
  logic        write;
  logic [31:0] value;
  logic [31:0] top;
  logic [31:0] next;
  logic [5:0]  count;
  logic        error;

  modport master (
    output push, pop, swap, write, value,
    input  top, next, count, error
  );

  modport slave (
    input  push, pop, swap, write, value,
    output top, next, count, error
  );
endinterface

// File: rtl/operand_stack.sv
// Operand stack with edge-accepted commands.
// Entries live in mem[0..DEPTH-1] with mem[0] as the top. Slots at or
// beyond count are always kept at zero, so mem[1] already reads as 0
// when only one entry is held and dead entries can never reach the
// outputs. top/next are taken straight from mem[0]/mem[1], so they are
// registers. A command executes once, on the first cycle its bundle is
// nonzero after a cycle of all-zero; the previous bundle resets to 4'b1111
// so a command held across reset release is not taken.
module operand_stack #(
  parameter int DEPTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  operand_stack_if.slave    bus
);

  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_WRITE   = 3'd1,
    OP_PUSH    = 3'd2,
    OP_POP     = 3'd3,
    OP_POPW    = 3'd4,
    OP_SWAP    = 3'd5,
    OP_ILLEGAL = 3'd6
  } op_t;

  logic [31:0] mem_r [DEPTH];
  logic [5:0]  count_r;
  logic        error_r;
  logic [3:0]  prev_bundle_r;

  logic [3:0]  bundle;
  logic        accept;
  logic        legal;
  op_t         op;

  assign bundle    = {bus.push, bus.pop, bus.swap, bus.write};
  assign bus.top   = mem_r[0];
  assign bus.next  = mem_r[1];
  assign bus.count = count_r;
  assign bus.error = error_r;

  // Decode the bundle into one operation and judge it against the occupancy.
  always_comb begin
    accept = (bundle != 4'b0000) && (prev_bundle_r == 4'b0000);
    op     = OP_NONE;
    legal  = 1'b0;
    case (bundle)
      4'b0000: begin
        op    = OP_NONE;
        legal = 1'b0;
      end
      4'b0001: begin
        op    = OP_WRITE;
        legal = 1'b1;
      end
      4'b1000: begin
        op    = OP_PUSH;
        legal = (count_r != DEPTH_C);
      end
      4'b0100: begin
        op    = OP_POP;
        legal = (count_r >= 6'd2);
      end
      4'b0101: begin
        op    = OP_POPW;
        legal = (count_r >= 6'd2);
      end
      4'b0010: begin
        op    = OP_SWAP;
        legal = (count_r >= 6'd2);
      end
      default: begin
        op    = OP_ILLEGAL;
        legal = 1'b0;
      end
    endcase
  end

  // Apply an accepted command to the entries, count and error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
      count_r       <= 6'd1;
      error_r       <= 1'b0;
      prev_bundle_r <= 4'b1111;
    end else begin
      prev_bundle_r <= bundle;
      if (accept) begin
        if (legal) begin
          error_r <= 1'b0;
          case (op)
            OP_WRITE: begin
              mem_r[0] <= bus.value;
            end
            OP_PUSH: begin
              for (int i = 1; i < DEPTH; i++) begin
                mem_r[i] <= mem_r[i-1];
              end
              mem_r[0] <= 32'd0;
              count_r  <= count_r + 6'd1;
            end
            OP_POP: begin
              for (int i = 0; i < DEPTH - 1; i++) begin
                mem_r[i] <= mem_r[i+1];
              end
              mem_r[DEPTH-1] <= 32'd0;
              count_r        <= count_r - 6'd1;
            end
            OP_POPW: begin
              // Top and next are consumed; the result replaces them.
              mem_r[0] <= bus.value;
              for (int i = 1; i < DEPTH - 1; i++) begin
                mem_r[i] <= mem_r[i+1];
              end
              mem_r[DEPTH-1] <= 32'd0;
              count_r        <= count_r - 6'd1;
            end
            OP_SWAP: begin
              mem_r[0] <= mem_r[1];
              mem_r[1] <= mem_r[0];
            end
            default: begin
              error_r <= 1'b1;
            end
          endcase
        end else begin
          error_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: directed scenarios followed by
// random command traffic, all compared against a queue-based stack model.
module tb_operand_stack;

  localparam int DEPTH = 8;

  logic clock;
  logic reset;
  operand_stack_if bus();

  operand_stack #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: m_stk[0] is the top of stack.
  logic [31:0] m_stk [$];
  logic [3:0]  m_prev;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_stk.push_back(32'd0);
    m_prev = 4'b1111;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic [31:0] v);
    logic        ok;
    logic [31:0] t;
    if (b != 4'b0000 && m_prev == 4'b0000) begin
      ok = 1'b0;
      case (b)
        4'b0001: begin m_stk[0] = v; ok = 1'b1; end
        4'b1000: if (m_stk.size() < DEPTH) begin m_stk.push_front(32'd0); ok = 1'b1; end
        4'b0100: if (m_stk.size() >= 2) begin t = m_stk.pop_front(); ok = 1'b1; end
        4'b0101: if (m_stk.size() >= 2) begin
                   t = m_stk.pop_front(); t = m_stk.pop_front();
                   m_stk.push_front(v); ok = 1'b1;
                 end
        4'b0010: if (m_stk.size() >= 2) begin
                   t = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = t; ok = 1'b1;
                 end
        default: ok = 1'b0;
      endcase
      m_err = ~ok;
    end
    m_prev = b;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".top"},   bus.top,   m_stk[0]);
    chk({tag, ".next"},  bus.next,  (m_stk.size() >= 2) ? m_stk[1] : 32'd0);
    chk({tag, ".count"}, {26'd0, bus.count}, 32'(m_stk.size()));
    chk({tag, ".error"}, {31'd0, bus.error}, {31'd0, m_err});
  endtask

  // One clock: drive at the falling edge, update model at the rising
  // edge, compare at the next falling edge.
  task automatic step(input logic [3:0] b, input logic [31:0] v, input string tag);
    {bus.push, bus.pop, bus.swap, bus.write} = b;
    bus.value = v;
    @(posedge clock);
    if (reset) model_reset();
    else model_step(b, v);
    @(negedge clock);
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    chk("rst.top",   bus.top, 32'd0);
    chk("rst.count", {26'd0, bus.count}, 32'd1);
    chk("rst.error", {31'd0, bus.error}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  rb;
    logic [3:0]  last_b;
    logic [31:0] rv;
    int          sel;

    reset = 1'b0;
    {bus.push, bus.pop, bus.swap, bus.write} = 4'b0000;
    bus.value = 32'd0;
    m_prev = 4'b1111;
    @(negedge clock);
    do_reset();
    step(4'b0000, 32'd0, "idle0");

    // Write 7 held for five cycles, value changes while held are ignored.
    step(4'b0001, 32'd7, "w7a");
    chk("r031.top1", bus.top, 32'd7);
    for (int i = 0; i < 4; i++) step(4'b0001, 32'd100 + 32'(i), "w7h");
    step(4'b0000, 32'd0, "w7r");
    chk("r031.top", bus.top, 32'd7);
    chk("r031.count", {26'd0, bus.count}, 32'd1);
    chk("r031.error", {31'd0, bus.error}, 32'd0);

    // Write 12, push, write 5, pop+write 17.
    step(4'b0001, 32'd12, "w12"); step(4'b0000, 32'd0, "i");
    step(4'b1000, 32'd0, "push"); step(4'b0000, 32'd0, "i");
    chk("r032.top", bus.top, 32'd0);
    chk("r032.next", bus.next, 32'd12);
    chk("r032.count", {26'd0, bus.count}, 32'd2);
    step(4'b0001, 32'd5, "w5"); step(4'b0000, 32'd0, "i");
    // Swap twice with top=5 next=12.
    step(4'b0010, 32'd0, "swap1"); step(4'b0000, 32'd0, "i");
    chk("r033.top1", bus.top, 32'd12);
    chk("r033.next1", bus.next, 32'd5);
    step(4'b0010, 32'd0, "swap2"); step(4'b0000, 32'd0, "i");
    chk("r033.top2", bus.top, 32'd5);
    chk("r033.next2", bus.next, 32'd12);
    step(4'b0101, 32'd17, "popw"); step(4'b0000, 32'd0, "i");
    chk("r032.top2", bus.top, 32'd17);
    chk("r032.next2", bus.next, 32'd0);
    chk("r032.count2", {26'd0, bus.count}, 32'd1);

    // Pop at count 1 is illegal; a following write clears error.
    step(4'b0100, 32'd0, "pop1"); step(4'b0000, 32'd0, "i");
    chk("r034.error", {31'd0, bus.error}, 32'd1);
    chk("r034.top", bus.top, 32'd17);
    step(4'b0101, 32'd9, "popw1"); step(4'b0000, 32'd0, "i");
    chk("r034.popw_err", {31'd0, bus.error}, 32'd1);
    step(4'b0001, 32'd3, "w3"); step(4'b0000, 32'd0, "i");
    chk("r034.error2", {31'd0, bus.error}, 32'd0);
    chk("r034.top2", bus.top, 32'd3);

    // Fill to DEPTH, overflow, then drain back to the bottom value.
    @(negedge clock); do_reset(); step(4'b0000, 32'd0, "i");
    step(4'b0001, 32'hCAFE_F00D, "wbot"); step(4'b0000, 32'd0, "i");
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(4'b1000, 32'd0, "fill"); step(4'b0000, 32'd0, "i");
    end
    chk("r035.full", {26'd0, bus.count}, 32'(DEPTH));
    step(4'b1000, 32'd0, "ovf"); step(4'b0000, 32'd0, "i");
    chk("r035.ovf_err", {31'd0, bus.error}, 32'd1);
    chk("r035.ovf_cnt", {26'd0, bus.count}, 32'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(4'b0100, 32'd0, "drain"); step(4'b0000, 32'd0, "i");
    end
    chk("r035.cnt1", {26'd0, bus.count}, 32'd1);
    chk("r035.bot", bus.top, 32'hCAFE_F00D);

    // Illegal combination, then reset while push is held.
    step(4'b1000, 32'd0, "p"); step(4'b0000, 32'd0, "i");
    step(4'b1010, 32'd0, "pushswap"); step(4'b0000, 32'd0, "i");
    chk("r036.err", {31'd0, bus.error}, 32'd1);
    chk("r036.cnt", {26'd0, bus.count}, 32'd2);
    step(4'b1000, 32'd0, "ph");
    step(4'b1000, 32'd0, "ph");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("r036.rst_cnt", {26'd0, bus.count}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(4'b1000, 32'd0, "held");
    chk("r036.noexec", {26'd0, bus.count}, 32'd1);
    step(4'b0000, 32'd0, "i");
    step(4'b1000, 32'd0, "repush");
    chk("r036.repush", {26'd0, bus.count}, 32'd2);

    // Random traffic.
    last_b = 4'b0000;
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: rb = 4'b0000;
        3:       rb = 4'b0001;
        4:       rb = 4'b1000;
        5:       rb = 4'b0100;
        6:       rb = 4'b0101;
        7:       rb = 4'b0010;
        8:       rb = 4'($urandom_range(0, 15));
        default: rb = last_b;
      endcase
      rv = $urandom;
      step(rb, rv, "rnd");
      last_b = rb;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
